fuzz_stim_gen: RTL and testbench

Pseudo-random stimulus generator for the D flip-flop fuzzing flow. It sits directly upstream of the `dff` under test and produces a burst of `{reset, enable, d}` vectors from a 16-bit Galois LFSR. Vectors are delivered over a valid/ready handshake, so a driver or capture stage can apply one vector per clock, or stall. It replaces file-based vector loading with on-chip generation of an arbitrary-length, seed-reproducible sequence.

---
 rtl/fuzz_pkg.sv | 12 +
 rtl/fuzz_lfsr.sv | 18 +
 rtl/fuzz_stim_gen.sv | 78 +++++++
 tb/tb_fuzz_stim_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fuzz_pkg.sv
// fuzz_pkg: shared state encoding, LFSR constants and vector bit positions for the DFF fuzzing flow.
package fuzz_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int VEC_RST = 2;
  localparam int VEC_EN = 1;
  localparam int VEC_D = 0;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/fuzz_lfsr.sv
// fuzz_lfsr: 16-bit Galois LFSR with seed load; a zero seed falls back to SEED to avoid lock-up.
module fuzz_lfsr
  import fuzz_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        advance,
  output logic [15:0] state
);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= SEED;
    else if (load) state <= (load_val == 16'h0000) ? SEED : load_val;
    else if (advance) state <= lfsr_step(state);
endmodule

// File: rtl/fuzz_stim_gen.sv
// fuzz_stim_gen: burst generator of {reset, enable, d} vectors from an LFSR over a valid/ready handshake.
module fuzz_stim_gen
  import fuzz_pkg::*;
#(
  parameter int          LFSR_W = 16,
  parameter logic [15:0] SEED   = DEFAULT_SEED,
  parameter int          CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [2:0]        vec_out,
  output logic [CNT_W-1:0]  vec_idx,
  output logic              busy,
  output logic              done
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [LFSR_W-1:0] s;
  logic adv;
  assign adv = vec_valid && vec_ready;
  fuzz_lfsr #(.SEED(SEED)) u_lfsr (
    .clk(clk),
    .reset(reset),
    .load(seed_load && state == IDLE),
    .load_val(seed_in),
    .advance(adv),
    .state(s)
  );
  always_comb begin
    vec_out = 3'b000;
    vec_out[VEC_RST] = vec_valid && (&s[2:0]);
    vec_out[VEC_EN] = vec_valid && s[7];
    vec_out[VEC_D] = vec_valid && s[11];
  end
  // vec_idx holds at cnt-1 on the final handshake so it never exceeds the burst range
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      vec_idx <= '0;
      vec_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          vec_idx <= '0;
          if (num_vec != '0) begin
            cnt <= num_vec;
            vec_valid <= 1'b1;
            state <= RUN;
          end else begin
            done <= 1'b1;
            state <= DONE;
          end
        end
        RUN: if (adv) begin
          if (vec_idx == cnt - CNT_W'(1)) begin
            vec_valid <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else vec_idx <= vec_idx + CNT_W'(1);
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_fuzz_stim_gen.sv
// tb_fuzz_stim_gen: directed and randomized bursts checked against a behavioural LFSR/vector model.
module tb_fuzz_stim_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] num_vec = '0;
  logic seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic vec_valid;
  logic vec_ready = 1'b0;
  logic [2:0] vec_out;
  logic [7:0] vec_idx;
  logic busy;
  logic done;
  int tests = 0;
  int fails = 0;
  logic [15:0] ms;

  fuzz_stim_gen dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
    .seed_load(seed_load), .seed_in(seed_in), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_out(vec_out), .vec_idx(vec_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_next(input logic [15:0] s);
    int v;
    v = int'(s) / 2;
    if (s % 2 == 1) v = v ^ 'hB400;
    return 16'(v);
  endfunction

  function automatic logic [2:0] m_vec(input logic [15:0] s);
    logic r;
    r = (s % 8) == 7;
    return {r, s[7], s[11]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, 32'(vec_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_vec"}, 32'(vec_out), 0);
  endtask

  // Runs a whole burst; expected vectors come from the model seed ms.
  task automatic burst(input int n, input int stall_idx, input int stall_len,
                       input int rand_pct, input bit poke);
    int got, cyc, stalled;
    bit rdy;
    start = 1'b1;
    num_vec = 8'(n);
    step();
    start = 1'b0;
    seed_load = 1'b0;
    if (n == 0) begin
      chk("zero_valid", 32'(vec_valid), 0);
      chk("zero_done", 32'(done), 1);
      chk("zero_busy", 32'(busy), 1);
      step();
      idle_chk("zero_after");
      return;
    end
    got = 0;
    cyc = 0;
    stalled = 0;
    while (got < n && cyc < 3000) begin
      chk("run_valid", 32'(vec_valid), 1);
      chk("run_busy", 32'(busy), 1);
      chk("run_done", 32'(done), 0);
      chk("run_vec", 32'(vec_out), 32'(m_vec(ms)));
      chk("run_idx", 32'(vec_idx), 32'(got));
      rdy = 1'b1;
      if (got == stall_idx && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else if (rand_pct > 0 && $urandom_range(99) < rand_pct) rdy = 1'b0;
      vec_ready = rdy;
      if (poke) begin
        start = $urandom_range(1);
        seed_load = $urandom_range(1);
        seed_in = 16'($urandom);
        num_vec = 8'($urandom);
      end
      step();
      start = 1'b0;
      seed_load = 1'b0;
      if (rdy) begin
        got++;
        ms = m_next(ms);
      end
      cyc++;
    end
    chk("burst_complete", 32'(got), 32'(n));
    vec_ready = 1'b0;
    chk("end_done", 32'(done), 1);
    chk("end_valid", 32'(vec_valid), 0);
    chk("end_vec", 32'(vec_out), 0);
    chk("end_busy", 32'(busy), 1);
    step();
    idle_chk("end_after");
  endtask

  initial begin
    #2;
    idle_chk("reset");
    chk("reset_idx", 32'(vec_idx), 0);
    step();
    reset = 1'b0;
    ms = 16'hACE1;
    step();
    idle_chk("post_reset");
    // Directed 2-vector burst against literal values.
    vec_ready = 1'b1;
    start = 1'b1;
    num_vec = 8'd2;
    step();
    start = 1'b0;
    chk("d2_vec0", 32'(vec_out), 32'h3);
    chk("d2_idx0", 32'(vec_idx), 0);
    chk("d2_busy", 32'(busy), 1);
    step();
    chk("d2_vec1", 32'(vec_out), 32'h0);
    chk("d2_idx1", 32'(vec_idx), 1);
    chk("d2_done_early", 32'(done), 0);
    step();
    chk("d2_done", 32'(done), 1);
    chk("d2_valid_off", 32'(vec_valid), 0);
    step();
    idle_chk("d2_after");
    ms = m_next(m_next(16'hACE1));
    vec_ready = 1'b0;
    repeat (2) step();
    // Stall on the second vector: outputs must hold while ready is low.
    burst(4, 1, 3, 0, 1'b0);
    // Zero seed falls back to the default seed.
    seed_load = 1'b1;
    seed_in = 16'h0000;
    step();
    seed_load = 1'b0;
    ms = 16'hACE1;
    burst(1, -1, 0, 0, 1'b0);
    // Seed and start in the same cycle.
    seed_load = 1'b1;
    seed_in = 16'h0007;
    ms = 16'h0007;
    burst(1, -1, 0, 0, 1'b0);
    // Zero-length burst.
    burst(0, -1, 0, 0, 1'b0);
    // Controls poked during RUN are ignored.
    burst(int'($urandom_range(5, 20)), -1, 0, 30, 1'b1);
    // Reset after the third handshake of a 10-vector burst.
    vec_ready = 1'b1;
    start = 1'b1;
    num_vec = 8'd10;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("mid_idx", 32'(vec_idx), 3);
    reset = 1'b1;
    #1;
    idle_chk("async_reset");
    chk("async_idx", 32'(vec_idx), 0);
    repeat (2) begin
      step();
      chk("reset_no_done", 32'(done), 0);
    end
    reset = 1'b0;
    vec_ready = 1'b0;
    step();
    ms = 16'hACE1;
    burst(1, -1, 0, 0, 1'b0);
    // Random bursts continue the sequence, including the maximum length.
    repeat (4) burst(int'($urandom_range(1, 30)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 4)), 25, 1'b0);
    burst(255, -1, 0, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
